// File: rtl/self_destruct_seq_pkg.sv
// Shared definitions for the self-destruct sequencer: state codes, the list
// of legal thermometer countdown codes, and small helpers.
package self_destruct_seq_pkg;

  // Encodings are visible on the state port and decoded by the LED/siren logic.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_FINAL     = 3'd3,
    ST_DETONATED = 3'd4,
    ST_ABORT     = 3'd5,
    ST_FAULT     = 3'd6
  } sd_state_t;

  // Number of distinct countdown levels (popcount 0..8).
  localparam int unsigned THERMO_LEVELS = 9;

  // Stage loaded on arming: the countdown counter starts full.
  localparam logic [3:0] STAGE_FULL = 4'd8;

  // Entry k holds the only legal code whose popcount is k (8'hFF >> (8-k)).
  localparam logic [THERMO_LEVELS-1:0][7:0] VALID_THERMO = {
    8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00
  };

  // A countdown step is legal if the level holds or drops by exactly one.
  function automatic logic legal_step(input logic [3:0] prev, input logic [3:0] next);
    return (next <= prev) && ((prev - next) <= 4'd1);
  endfunction

  // Counter width for a tick count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/self_destruct_seq_if.sv
// Status/control bundle between the sequencer and its surroundings
// (voter, debouncers, countdown counter, LED and siren logic).
interface self_destruct_seq_if;

  logic       in_combat;
  logic       critical;
  logic [7:0] countdown;
  logic       confirm;

  logic [2:0] state;
  logic       armed;
  logic [3:0] stage;
  logic       siren_en;
  logic       detonate;
  logic       fault;

  // Environment side: drives the sensed inputs, observes the status.
  modport master (
    output in_combat, critical, countdown, confirm,
    input  state, armed, stage, siren_en, detonate, fault
  );

  // Sequencer side.
  modport slave (
    input  in_combat, critical, countdown, confirm,
    output state, armed, stage, siren_en, detonate, fault
  );

endinterface

// File: rtl/self_destruct_seq_thermo_check.sv
// Combinational check of the countdown thermometer code: flags whether the
// code is one of the legal 2^k-1 patterns and reports its popcount.
module thermo_check
  import self_destruct_seq_pkg::*;
(
  input  logic [7:0] countdown,
  output logic       valid,
  output logic [3:0] popcount
);

  // Match against the legal code list and count set bits.
  always_comb begin
    valid    = 1'b0;
    popcount = '0;
    for (int unsigned k = 0; k < THERMO_LEVELS; k++) begin
      if (countdown == VALID_THERMO[k]) begin
        valid = 1'b1;
      end
    end
    for (int unsigned b = 0; b < 8; b++) begin
      popcount = popcount + 4'(countdown[b]);
    end
  end

endmodule

// File: rtl/self_destruct_seq.sv
// Self-destruct sequencer: arms after a sustained critical condition, tracks
// the thermometer countdown, fires on operator confirm at zero, aborts safely
// when combat ends and latches a fault on any corrupt countdown code.
module self_destruct_seq
  import self_destruct_seq_pkg::*;
#(
  parameter int unsigned ARM_TICKS     = 50,
  parameter int unsigned CONFIRM_TICKS = 300,
  parameter int unsigned ABORT_TICKS   = 100
) (
  input  logic               clk,
  input  logic               reset,
  self_destruct_seq_if.slave bus
);

  localparam int unsigned ARM_W   = cnt_width(ARM_TICKS);
  localparam int unsigned WIN_W   = cnt_width(CONFIRM_TICKS);
  localparam int unsigned ABORT_W = cnt_width(ABORT_TICKS);

  localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_TICKS - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(CONFIRM_TICKS - 1);
  localparam logic [ABORT_W-1:0] ABORT_LAST = ABORT_W'(ABORT_TICKS - 1);

  sd_state_t          state_q, state_n;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_n;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_n;
  logic [ABORT_W-1:0] abort_cnt_q, abort_cnt_n;
  logic [3:0]         stage_q, stage_n;

  logic               code_valid;
  logic [3:0]         code_pop;

  thermo_check u_thermo_check (
    .countdown (bus.countdown),
    .valid     (code_valid),
    .popcount  (code_pop)
  );

  // Next-state, counter and stage logic.
  always_comb begin
    state_n     = state_q;
    arm_cnt_n   = arm_cnt_q;
    win_cnt_n   = win_cnt_q;
    abort_cnt_n = abort_cnt_q;
    stage_n     = stage_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_combat && bus.critical) begin
          state_n   = ST_ARMING;
          arm_cnt_n = '0;
        end
      end

      ST_ARMING: begin
        if (!bus.in_combat || !bus.critical) begin
          state_n = ST_IDLE;
        end else if (arm_cnt_q == ARM_LAST) begin
          // Stage starts full so the first FF code is a legal hold.
          state_n = ST_COUNTDOWN;
          stage_n = STAGE_FULL;
        end else begin
          arm_cnt_n = arm_cnt_q + ARM_W'(1);
        end
      end

      ST_COUNTDOWN: begin
        if (!bus.in_combat) begin
          state_n     = ST_ABORT;
          abort_cnt_n = '0;
        end else if (!code_valid || !legal_step(stage_q, code_pop)) begin
          state_n = ST_FAULT;
        end else begin
          stage_n = code_pop;
          if (code_pop == '0) begin
            state_n   = ST_FINAL;
            win_cnt_n = '0;
          end
        end
      end

      ST_FINAL: begin
        // Abort beats confirm; a corrupt code blocks firing.
        if (!bus.in_combat) begin
          state_n     = ST_ABORT;
          abort_cnt_n = '0;
        end else if (bus.countdown != '0) begin
          state_n = ST_FAULT;
        end else if (bus.confirm) begin
          state_n = ST_DETONATED;
        end else if (win_cnt_q == WIN_LAST) begin
          state_n     = ST_ABORT;
          abort_cnt_n = '0;
        end else begin
          win_cnt_n = win_cnt_q + WIN_W'(1);
        end
      end

      ST_ABORT: begin
        if (abort_cnt_q == ABORT_LAST) begin
          state_n = ST_IDLE;
          stage_n = '0;
        end else begin
          abort_cnt_n = abort_cnt_q + ABORT_W'(1);
        end
      end

      ST_DETONATED, ST_FAULT: begin
        state_n = state_q;
      end

      default: begin
        state_n = ST_FAULT;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      arm_cnt_q    <= '0;
      win_cnt_q    <= '0;
      abort_cnt_q  <= '0;
      stage_q      <= '0;
      bus.armed    <= 1'b0;
      bus.siren_en <= 1'b0;
      bus.detonate <= 1'b0;
      bus.fault    <= 1'b0;
    end else begin
      state_q      <= state_n;
      arm_cnt_q    <= arm_cnt_n;
      win_cnt_q    <= win_cnt_n;
      abort_cnt_q  <= abort_cnt_n;
      stage_q      <= stage_n;
      bus.armed    <= (state_n == ST_COUNTDOWN) || (state_n == ST_FINAL);
      bus.siren_en <= (state_n == ST_COUNTDOWN) || (state_n == ST_FINAL) ||
                      (state_n == ST_ABORT);
      // Sticky: only reset clears these.
      bus.detonate <= bus.detonate | (state_n == ST_DETONATED);
      bus.fault    <= bus.fault | (state_n == ST_FAULT);
    end
  end

  assign bus.state = state_q;
  assign bus.stage = stage_q;

endmodule

// File: tb/tb_self_destruct_seq.sv
// Bench for self_destruct_seq: directed scenarios followed by a random soak,
// every cycle compared against a dwell-time reference model.
module tb_self_destruct_seq;

  localparam int ARM_TICKS     = 50;
  localparam int CONFIRM_TICKS = 300;
  localparam int ABORT_TICKS   = 100;

  localparam int S_IDLE = 0, S_ARMING = 1, S_COUNTDOWN = 2, S_FINAL = 3,
                 S_DETONATED = 4, S_ABORT = 5, S_FAULT = 6;

  logic clk;
  logic reset;

  self_destruct_seq_if sif ();

  self_destruct_seq #(
    .ARM_TICKS     (ARM_TICKS),
    .CONFIRM_TICKS (CONFIRM_TICKS),
    .ABORT_TICKS   (ABORT_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state code, stored stage, cycles spent in current state.
  int m_state = S_IDLE;
  int m_stage = 0;
  int m_dwell = 0;

  logic [7:0] full = 8'hFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic [7:0] cd, cd_inc;
    int  pc;
    bit  is_thermo;
    cd        = sif.countdown;
    cd_inc    = cd + 8'd1;
    is_thermo = ((cd & cd_inc) == 8'd0);
    pc        = $countones(cd);
    if (reset) begin
      m_state = S_IDLE;
      m_stage = 0;
      m_dwell = 0;
      return;
    end
    case (m_state)
      S_IDLE: if (sif.in_combat && sif.critical) begin
        m_state = S_ARMING;
        m_dwell = 0;
      end
      S_ARMING: begin
        if (!sif.in_combat || !sif.critical) m_state = S_IDLE;
        else begin
          m_dwell++;
          if (m_dwell == ARM_TICKS) begin
            m_state = S_COUNTDOWN;
            m_stage = 8;
          end
        end
      end
      S_COUNTDOWN: begin
        if (!sif.in_combat) begin
          m_state = S_ABORT;
          m_dwell = 0;
        end else if (!is_thermo || pc > m_stage || (m_stage - pc) > 1) begin
          m_state = S_FAULT;
        end else begin
          m_stage = pc;
          if (pc == 0) begin
            m_state = S_FINAL;
            m_dwell = 0;
          end
        end
      end
      S_FINAL: begin
        if (!sif.in_combat) begin
          m_state = S_ABORT;
          m_dwell = 0;
        end else if (cd != 8'd0) begin
          m_state = S_FAULT;
        end else if (sif.confirm) begin
          m_state = S_DETONATED;
        end else begin
          m_dwell++;
          if (m_dwell == CONFIRM_TICKS) begin
            m_state = S_ABORT;
            m_dwell = 0;
          end
        end
      end
      S_ABORT: begin
        m_dwell++;
        if (m_dwell == ABORT_TICKS) begin
          m_state = S_IDLE;
          m_stage = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [10:0] model_vec();
    bit arm, sir;
    arm = (m_state == S_COUNTDOWN) || (m_state == S_FINAL);
    sir = arm || (m_state == S_ABORT);
    return {3'(m_state), arm, 4'(m_stage), sir,
            (m_state == S_DETONATED), (m_state == S_FAULT)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {sif.state, sif.armed, sif.stage, sif.siren_en, sif.detonate, sif.fault};
  endfunction

  // One clock: update the model at the edge, compare all outputs 1 unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outputs_vs_model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    sif.in_combat  = 1'b0;
    sif.critical   = 1'b0;
    sif.confirm    = 1'b0;
    sif.countdown  = 8'hFF;
    tick();
    check("reset_all_zero", 32'(dut_vec()), 32'd0);
    reset = 1'b0;
  endtask

  task automatic arm();
    sif.in_combat = 1'b1;
    sif.critical  = 1'b1;
    sif.confirm   = 1'b0;
    sif.countdown = 8'hFF;
    repeat (ARM_TICKS) tick();
    check("still_arming_at_50", 32'(sif.state), 32'd1);
    tick();
    check("countdown_at_51", 32'(sif.state), 32'd2);
    check("armed_at_51", 32'(sif.armed), 32'd1);
  endtask

  task automatic count_down_to(input int n);
    for (int k = 8; k >= n; k--) begin
      sif.countdown = full >> (8 - k);
      tick();
      check("stage_follows_code", 32'(sif.stage), 32'(k));
    end
  endtask

  initial begin
    int          d;
    int          k;
    int          r;
    logic [7:0]  code;
    logic [7:0]  code_inc;

    reset         = 1'b1;
    sif.in_combat = 1'b0;
    sif.critical  = 1'b0;
    sif.confirm   = 1'b0;
    sif.countdown = 8'hFF;
    do_reset();

    // Full countdown then confirm after a random wait.
    arm();
    count_down_to(0);
    check("final_state", 32'(sif.state), 32'd3);
    repeat ($urandom_range(0, 20)) tick();
    sif.confirm = 1'b1;
    tick();
    check("detonate_set", 32'(sif.detonate), 32'd1);
    check("detonated_state", 32'(sif.state), 32'd4);
    sif.confirm   = 1'b0;
    sif.in_combat = 1'b0;
    sif.countdown = 8'h5A;
    repeat (10) tick();
    check("detonate_held", 32'(sif.detonate), 32'd1);
    do_reset();

    // Critical dropped at cycle 30, then at a random cycle up to the last one.
    sif.in_combat = 1'b1;
    sif.critical  = 1'b1;
    repeat (29) tick();
    sif.critical = 1'b0;
    tick();
    check("crit_drop_30_idle", 32'(sif.state), 32'd0);
    d = $urandom_range(2, ARM_TICKS);
    sif.critical = 1'b1;
    repeat (d - 1) tick();
    sif.critical = 1'b0;
    tick();
    check("crit_drop_rand_idle", 32'(sif.state), 32'd0);
    do_reset();

    // Abort at stage 4, full abort dwell, then fresh re-arm from IDLE.
    arm();
    count_down_to(4);
    sif.in_combat = 1'b0;
    tick();
    check("abort_state", 32'(sif.state), 32'd5);
    check("abort_siren", 32'(sif.siren_en), 32'd1);
    check("abort_stage_kept", 32'(sif.stage), 32'd4);
    repeat (ABORT_TICKS - 1) tick();
    check("abort_last_cycle", 32'(sif.state), 32'd5);
    tick();
    check("abort_to_idle", 32'(sif.state), 32'd0);
    check("abort_stage_clear", 32'(sif.stage), 32'd0);
    sif.in_combat = 1'b1;
    sif.critical  = 1'b1;
    sif.countdown = 8'hFF;
    tick();
    check("rearm_from_idle", 32'(sif.state), 32'd1);
    do_reset();

    // Corrupt codes.
    arm();
    count_down_to($urandom_range(1, 8));
    sif.countdown = 8'h5A;
    tick();
    check("corrupt_5a_fault", 32'(sif.fault), 32'd1);
    check("corrupt_5a_state", 32'(sif.state), 32'd6);
    do_reset();

    arm();
    count_down_to(5);
    do begin
      code     = 8'($urandom);
      code_inc = code + 8'd1;
    end while ((code & code_inc) == 8'd0);
    sif.countdown = code;
    tick();
    check("corrupt_rand_fault", 32'(sif.fault), 32'd1);
    do_reset();

    arm();
    count_down_to(6);
    sif.countdown = 8'h7F;
    tick();
    check("rise_3f_7f_fault", 32'(sif.fault), 32'd1);
    do_reset();

    arm();
    count_down_to(6);
    sif.countdown = 8'h0F;
    tick();
    check("skip_3f_0f_fault", 32'(sif.fault), 32'd1);
    do_reset();

    // Confirm window expiry.
    arm();
    count_down_to(0);
    repeat (CONFIRM_TICKS - 1) tick();
    check("window_last_cycle", 32'(sif.state), 32'd3);
    tick();
    check("window_expired_abort", 32'(sif.state), 32'd5);
    do_reset();

    // Confirm and combat end together: abort wins.
    arm();
    count_down_to(0);
    sif.in_combat = 1'b0;
    sif.confirm   = 1'b1;
    tick();
    check("tie_abort_state", 32'(sif.state), 32'd5);
    check("tie_no_detonate", 32'(sif.detonate), 32'd0);
    sif.confirm = 1'b0;
    do_reset();

    // Reset while in FINAL.
    arm();
    count_down_to(0);
    reset = 1'b1;
    tick();
    check("reset_in_final", 32'(dut_vec()), 32'd0);
    reset = 1'b0;

    // Random soak with a mostly well-behaved countdown source.
    k = 8;
    for (int c = 0; c < 4000; c++) begin
      reset = 1'b0;
      if (m_state == S_DETONATED || m_state == S_FAULT)
        reset = ($urandom_range(0, 7) == 0);
      else if ($urandom_range(0, 599) == 0)
        reset = 1'b1;
      sif.in_combat = ($urandom_range(0, 149) != 0);
      sif.critical  = ($urandom_range(0, 59) != 0);
      sif.confirm   = (m_state == S_FINAL) ? ($urandom_range(0, 199) == 0)
                                           : ($urandom_range(0, 19) == 0);
      if (m_state == S_IDLE || m_state == S_ARMING) k = 8;
      else if (m_state == S_COUNTDOWN && k > 0 && $urandom_range(0, 3) == 0) k--;
      code = full >> (8 - k);
      r = $urandom_range(0, 299);
      if (r == 0) code = 8'($urandom);
      else if (r == 1 && k < 8) code = full >> (7 - k);
      else if (r == 2 && k >= 2) code = full >> (10 - k);
      sif.countdown = code;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
